ticket_vend_ctrl: RTL and testbench

//  Top-level sequencer for the TicketSeller datapath. Latches a ticket selection and accumulates coin credit.

---
 rtl/ticket_vend_ctrl_pkg.sv | 23 ++
 rtl/ticket_vend_ctrl_credit_acc.sv | 47 ++++
 rtl/ticket_vend_ctrl.sv | 144 ++++++++++++++
 tb/tb_ticket_vend_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ticket_vend_ctrl_pkg.sv
// Shared definitions for the ticket vending controller: state encoding,
// default prices and coin values.
package ticket_vend_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_COLLECT  = 2'd1,
        S_DISPENSE = 2'd2,
        S_CHANGE   = 2'd3
    } state_t;

    localparam int DEF_CW         = 5;
    localparam int DEF_PRICE_1    = 2;
    localparam int DEF_PRICE_2    = 3;
    localparam int DEF_PRICE_3    = 5;
    localparam int DEF_MAX_CREDIT = 20;
    localparam int DEF_DISP_CYC   = 4;
    localparam int DEF_TIMEOUT    = 255;

    localparam int COIN1_VAL = 1;
    localparam int COIN5_VAL = 5;

endpackage

// File: rtl/ticket_vend_ctrl_credit_acc.sv
// Coin credit accumulator: adds inserted coins to the credit register,
// rejects any add that would exceed MAX_CREDIT, and flags rejected coins.
// credit_nxt is the post-coin value before any clear, so the controller can
// refund coins that arrive in the same cycle as a cancel.
module credit_acc
    import ticket_vend_ctrl_pkg::*;
#(
    parameter int CW         = DEF_CW,
    parameter int MAX_CREDIT = DEF_MAX_CREDIT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic          coin1,
    input  logic          coin5,
    output logic [CW-1:0] credit,
    output logic [CW-1:0] credit_nxt,
    output logic          coin_rej
);

    logic [CW:0] add;
    logic [CW:0] sum;
    logic        fits;

    // Saturation check is done one bit wider so overflow cannot wrap past the limit
    always_comb begin
        add = '0;
        if (coin1) add = add + (CW+1)'(COIN1_VAL);
        if (coin5) add = add + (CW+1)'(COIN5_VAL);
        sum        = {1'b0, credit} + add;
        fits       = (sum <= (CW+1)'(MAX_CREDIT));
        credit_nxt = (en && fits) ? sum[CW-1:0] : credit;
    end

    // Credit register and registered reject pulse (one cycle after the coin)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            credit   <= '0;
            coin_rej <= 1'b0;
        end else begin
            credit   <= clr ? '0 : credit_nxt;
            coin_rej <= (coin1 | coin5) & ~(en & fits);
        end
    end

endmodule

// File: rtl/ticket_vend_ctrl.sv
// Ticket vending sequencer: latches a selection, collects coin credit,
// strobes the dispenser for DISP_CYC cycles and returns change through a
// valid/ack handshake. Cancel or an idle timeout refunds collected credit.
module ticket_vend_ctrl
    import ticket_vend_ctrl_pkg::*;
#(
    parameter int CW         = DEF_CW,
    parameter int PRICE_1    = DEF_PRICE_1,
    parameter int PRICE_2    = DEF_PRICE_2,
    parameter int PRICE_3    = DEF_PRICE_3,
    parameter int MAX_CREDIT = DEF_MAX_CREDIT,
    parameter int DISP_CYC   = DEF_DISP_CYC,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sel_valid,
    input  logic [1:0]    sel,
    input  logic          coin1,
    input  logic          coin5,
    input  logic          cancel,
    input  logic          chg_ack,
    output logic          tkt_out,
    output logic          chg_valid,
    output logic [CW-1:0] chg_amt,
    output logic          coin_rej,
    output logic [CW-1:0] credit,
    output logic          busy
);

    localparam int DW = $clog2(DISP_CYC + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t        state;
    logic [CW-1:0] price;
    logic [DW-1:0] disp_cnt;
    logic [TW-1:0] to_cnt;
    logic [CW-1:0] credit_nxt;
    logic          acc_en;
    logic          acc_clr;
    logic          abort;
    logic          disp_done;
    logic          coin_ok;

    function automatic logic [CW-1:0] sel_price(input logic [1:0] s);
        case (s)
            2'd1:    return CW'(PRICE_1);
            2'd2:    return CW'(PRICE_2);
            default: return CW'(PRICE_3);
        endcase
    endfunction

    // Coins only count while collecting; credit drops on refund or end of dispense
    always_comb begin
        acc_en    = (state == S_COLLECT);
        coin_ok   = (credit_nxt != credit);
        abort     = (state == S_COLLECT) && (cancel || (to_cnt == TW'(TIMEOUT)));
        disp_done = (state == S_DISPENSE) && (disp_cnt == DW'(DISP_CYC));
        acc_clr   = abort || disp_done;
    end

    credit_acc #(
        .CW         (CW),
        .MAX_CREDIT (MAX_CREDIT)
    ) u_credit_acc (
        .clk        (clk),
        .rst        (rst),
        .clr        (acc_clr),
        .en         (acc_en),
        .coin1      (coin1),
        .coin5      (coin5),
        .credit     (credit),
        .credit_nxt (credit_nxt),
        .coin_rej   (coin_rej)
    );

    // Main sequencer with registered outputs, dispense and timeout counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            price     <= '0;
            disp_cnt  <= '0;
            to_cnt    <= '0;
            tkt_out   <= 1'b0;
            chg_valid <= 1'b0;
            chg_amt   <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (sel_valid && (sel != 2'd0)) begin
                        price  <= sel_price(sel);
                        to_cnt <= '0;
                        state  <= S_COLLECT;
                        busy   <= 1'b1;
                    end
                end
                S_COLLECT: begin
                    to_cnt <= coin_ok ? '0 : to_cnt + TW'(1);
                    // Abort wins over a simultaneous price match: the user asked out
                    if (abort) begin
                        if (credit_nxt != '0) begin
                            chg_valid <= 1'b1;
                            chg_amt   <= credit_nxt;
                            state     <= S_CHANGE;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end else if (credit_nxt >= price) begin
                        disp_cnt <= '0;
                        state    <= S_DISPENSE;
                    end
                end
                S_DISPENSE: begin
                    // First DISPENSE cycle has tkt_out low; it then stays high DISP_CYC cycles
                    if (!disp_done) begin
                        tkt_out  <= 1'b1;
                        disp_cnt <= disp_cnt + DW'(1);
                    end else begin
                        tkt_out <= 1'b0;
                        if (credit > price) begin
                            chg_valid <= 1'b1;
                            chg_amt   <= credit - price;
                            state     <= S_CHANGE;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                S_CHANGE: begin
                    if (chg_ack) begin
                        chg_valid <= 1'b0;
                        chg_amt   <= '0;
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ticket_vend_ctrl.sv
// Self-checking bench for ticket_vend_ctrl: directed vector table, hand-written
// corner sequences (saturation, timeout, async reset) and a randomized run
// against a behavioural model.
module tb_ticket_vend_ctrl;

    localparam int CW         = 5;
    localparam int MAX_CREDIT = 20;
    localparam int DISP_CYC   = 4;
    localparam int TIMEOUT    = 255;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          sel_valid, coin1, coin5, cancel, chg_ack;
    logic [1:0]    sel;
    logic          tkt_out, chg_valid, coin_rej, busy;
    logic [CW-1:0] chg_amt, credit;

    // second instance with an unreachable price, used for the saturation corner
    logic          s_sel_valid, s_coin1, s_coin5, s_cancel, s_chg_ack;
    logic [1:0]    s_sel;
    logic          s_tkt_out, s_chg_valid, s_coin_rej, s_busy;
    logic [CW-1:0] s_chg_amt, s_credit;

    int checks = 0;
    int errors = 0;

    always #10 clk = ~clk;

    ticket_vend_ctrl dut (
        .clk(clk), .rst(rst), .sel_valid(sel_valid), .sel(sel), .coin1(coin1),
        .coin5(coin5), .cancel(cancel), .chg_ack(chg_ack), .tkt_out(tkt_out),
        .chg_valid(chg_valid), .chg_amt(chg_amt), .coin_rej(coin_rej),
        .credit(credit), .busy(busy)
    );

    ticket_vend_ctrl #(.PRICE_3(31)) dut_sat (
        .clk(clk), .rst(rst), .sel_valid(s_sel_valid), .sel(s_sel), .coin1(s_coin1),
        .coin5(s_coin5), .cancel(s_cancel), .chg_ack(s_chg_ack), .tkt_out(s_tkt_out),
        .chg_valid(s_chg_valid), .chg_amt(s_chg_amt), .coin_rej(s_coin_rej),
        .credit(s_credit), .busy(s_busy)
    );

    typedef struct {
        logic       sv;
        logic [1:0] sel;
        logic       c1, c5, cn, ack;
        logic [13:0] exp;   // {tkt, cv, amt[4:0], rej, credit[4:0], busy}
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input int sv, input int sl, input int c1, input int c5,
                                input int cn, input int ak, input int tk, input int cv,
                                input int amt, input int rj, input int cr, input int bz);
        vec_t v;
        v.sv  = sv[0];
        v.sel = sl[1:0];
        v.c1  = c1[0];
        v.c5  = c5[0];
        v.cn  = cn[0];
        v.ack = ak[0];
        v.exp = {tk[0], cv[0], amt[4:0], rj[0], cr[4:0], bz[0]};
        return v;
    endfunction

    function automatic logic [13:0] outs();
        return {tkt_out, chg_valid, chg_amt, coin_rej, credit, busy};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic sv, input logic [1:0] sl, input logic c1,
                         input logic c5, input logic cn, input logic ak);
        sel_valid = sv; sel = sl; coin1 = c1; coin5 = c5; cancel = cn; chg_ack = ak;
    endtask

    task automatic s_drive(input logic sv, input logic [1:0] sl, input logic c1,
                           input logic c5, input logic cn, input logic ak);
        s_sel_valid = sv; s_sel = sl; s_coin1 = c1; s_coin5 = c5; s_cancel = cn; s_chg_ack = ak;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // behavioural reference: transaction phase plus plain integer bookkeeping
    int m_mode, m_credit, m_price, m_tick, m_idle, m_chg;
    int e_tkt, e_cv, e_amt, e_rej, e_busy;
    int prices[4] = '{0, 2, 3, 5};

    task automatic model_step(input int sv, input int sl, input int c1, input int c5,
                              input int cn, input int ak);
        int  add;
        bit  abort;
        add   = c1 + 5 * c5;
        e_rej = 0;
        e_tkt = 0;
        case (m_mode)
            0: begin
                e_rej = (add > 0);
                if (sv != 0 && sl != 0) begin
                    m_price = prices[sl];
                    m_mode  = 1;
                    m_idle  = 0;
                end
            end
            1: begin
                abort = (cn != 0) || (m_idle == TIMEOUT);
                if (add > 0 && m_credit + add <= MAX_CREDIT) begin
                    m_credit += add;
                    m_idle = 0;
                end else begin
                    if (add > 0) e_rej = 1;
                    m_idle++;
                end
                if (abort) begin
                    m_chg    = m_credit;
                    m_credit = 0;
                    m_mode   = (m_chg > 0) ? 3 : 0;
                end else if (m_credit >= m_price) begin
                    m_mode = 2;
                    m_tick = 0;
                end
            end
            2: begin
                e_rej = (add > 0);
                if (m_tick < DISP_CYC) begin
                    e_tkt = 1;
                    m_tick++;
                end else begin
                    m_chg    = m_credit - m_price;
                    m_credit = 0;
                    m_mode   = (m_chg > 0) ? 3 : 0;
                end
            end
            default: begin
                e_rej = (add > 0);
                if (ak != 0) m_mode = 0;
            end
        endcase
        e_cv   = (m_mode == 3) ? 1 : 0;
        e_amt  = (m_mode == 3) ? m_chg : 0;
        e_busy = (m_mode != 0) ? 1 : 0;
    endtask

    initial begin
        int n;
        drive(0, 0, 0, 0, 0, 0);
        s_drive(0, 0, 0, 0, 0, 0);

        // reset state
        repeat (3) cyc();
        chk("reset_outs", outs(), 0);
        chk("reset_outs_sat", {s_tkt_out, s_chg_valid, s_chg_amt, s_coin_rej, s_credit, s_busy}, 0);
        @(negedge clk);
        rst = 1'b1;
        cyc();

        // directed vectors: exact pay, overpay, double coin, cancel, ignored inputs
        tbl.push_back(mk(1,2,0,0,0,0, 0,0,0,0,0,1));
        tbl.push_back(mk(0,0,1,0,0,0, 0,0,0,0,1,1));
        tbl.push_back(mk(0,0,1,0,0,0, 0,0,0,0,2,1));
        tbl.push_back(mk(0,0,1,0,0,0, 0,0,0,0,3,1));
        repeat (4) tbl.push_back(mk(0,0,0,0,0,0, 1,0,0,0,3,1));
        tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,0));
        tbl.push_back(mk(0,0,1,0,0,0, 0,0,0,1,0,0));
        tbl.push_back(mk(0,0,0,0,0,1, 0,0,0,0,0,0));
        tbl.push_back(mk(1,1,0,0,0,0, 0,0,0,0,0,1));
        tbl.push_back(mk(0,0,0,1,0,0, 0,0,0,0,5,1));
        repeat (4) tbl.push_back(mk(0,0,0,0,0,0, 1,0,0,0,5,1));
        tbl.push_back(mk(0,0,0,0,0,0, 0,1,3,0,0,1));
        tbl.push_back(mk(0,0,1,0,0,0, 0,1,3,1,0,1));
        tbl.push_back(mk(0,0,0,0,0,0, 0,1,3,0,0,1));
        tbl.push_back(mk(0,0,0,0,0,1, 0,0,0,0,0,0));
        tbl.push_back(mk(1,3,0,0,0,0, 0,0,0,0,0,1));
        tbl.push_back(mk(0,0,1,1,0,0, 0,0,0,0,6,1));
        repeat (4) tbl.push_back(mk(0,0,0,0,0,0, 1,0,0,0,6,1));
        tbl.push_back(mk(0,0,0,0,0,0, 0,1,1,0,0,1));
        tbl.push_back(mk(0,0,0,0,0,1, 0,0,0,0,0,0));
        tbl.push_back(mk(1,3,0,0,0,0, 0,0,0,0,0,1));
        tbl.push_back(mk(1,1,1,0,0,0, 0,0,0,0,1,1));
        tbl.push_back(mk(0,0,1,0,0,0, 0,0,0,0,2,1));
        tbl.push_back(mk(0,0,1,0,1,0, 0,1,3,0,0,1));
        tbl.push_back(mk(0,0,0,0,0,1, 0,0,0,0,0,0));
        tbl.push_back(mk(1,1,0,0,0,0, 0,0,0,0,0,1));
        tbl.push_back(mk(0,0,0,0,1,0, 0,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,0, 0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,0));
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].sv, tbl[i].sel, tbl[i].c1, tbl[i].c5, tbl[i].cn, tbl[i].ack);
            cyc();
            chk($sformatf("vec[%0d]", i), outs(), tbl[i].exp);
        end
        drive(0, 0, 0, 0, 0, 0);

        // saturation at the credit ceiling (price 31 never reached)
        s_drive(1, 3, 0, 0, 0, 0); cyc();
        s_drive(0, 0, 0, 1, 0, 0); repeat (3) cyc();
        s_drive(0, 0, 1, 0, 0, 0); repeat (4) cyc();
        chk("sat_credit19", s_credit, 19);
        s_drive(0, 0, 0, 1, 0, 0); cyc();
        chk("sat_rej_coin5", {s_coin_rej, s_credit}, {1'b1, 5'd19});
        s_drive(0, 0, 1, 0, 0, 0); cyc();
        chk("sat_exact_max", {s_coin_rej, s_credit}, {1'b0, 5'd20});
        cyc();
        chk("sat_rej_at_max", {s_coin_rej, s_credit}, {1'b1, 5'd20});
        s_drive(0, 0, 0, 0, 1, 0); cyc();
        chk("sat_refund", {s_chg_valid, s_chg_amt, s_credit}, {1'b1, 5'd20, 5'd0});
        s_drive(0, 0, 0, 0, 0, 1); cyc();
        chk("sat_done", {s_chg_valid, s_busy}, 0);
        s_drive(0, 0, 0, 0, 0, 0);

        // idle timeout refunds the collected credit
        drive(1, 2, 0, 0, 0, 0); cyc();
        drive(0, 0, 1, 0, 0, 0); cyc();
        drive(0, 0, 0, 0, 0, 0);
        n = 0;
        for (int k = 1; k <= 300; k++) begin
            cyc();
            if (chg_valid) begin
                n = k;
                break;
            end
        end
        chk("timeout_cycles", n, TIMEOUT + 1);
        chk("timeout_amt", chg_amt, 1);
        drive(0, 0, 0, 0, 0, 1); cyc();
        chk("timeout_idle", {chg_valid, busy}, 0);
        drive(0, 0, 0, 0, 0, 0);

        // asynchronous reset in the middle of dispensing
        drive(1, 1, 0, 0, 0, 0); cyc();
        drive(0, 0, 0, 1, 0, 0); cyc();
        drive(0, 0, 0, 0, 0, 0); cyc(); cyc();
        chk("pre_reset_tkt", {tkt_out, busy, credit}, {1'b1, 1'b1, 5'd5});
        #3 rst = 1'b0;
        #1;
        chk("async_reset", {tkt_out, busy, credit, chg_valid}, 0);
        cyc();
        @(negedge clk);
        rst = 1'b1;
        cyc();
        chk("post_reset_idle", outs(), 0);
        drive(0, 0, 1, 0, 0, 0); cyc();
        chk("post_reset_rej", outs(), 14'h0040);
        drive(0, 0, 0, 0, 0, 0); cyc();
        chk("post_reset_quiet", outs(), 0);

        // randomized traffic against the behavioural model
        m_mode = 0; m_credit = 0; m_price = 0; m_tick = 0; m_idle = 0; m_chg = 0;
        for (int i = 0; i < 2000; i++) begin
            int sv, sl, c1, c5, cn, ak;
            sv = ($urandom_range(0, 3) == 0);
            sl = $urandom_range(0, 3);
            c1 = ($urandom_range(0, 2) == 0);
            c5 = ($urandom_range(0, 5) == 0);
            cn = ($urandom_range(0, 19) == 0);
            ak = ($urandom_range(0, 2) == 0);
            drive(sv[0], sl[1:0], c1[0], c5[0], cn[0], ak[0]);
            model_step(sv, sl, c1, c5, cn, ak);
            cyc();
            chk($sformatf("rand[%0d]", i), outs(),
                {e_tkt[0], e_cv[0], e_amt[4:0], e_rej[0], m_credit[4:0], e_busy[0]});
        end
        drive(0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
